// File: rtl/rv_pkg.sv
// rv_pkg: shared opcode constants, format enum and instruction-field struct
// used by the instruction encoder and its field packer.
package rv_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_BAD
    } fmt_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [63:0] imm;
    } instr_fields_t;

    function automatic fmt_t opc_fmt(input logic [6:0] opc);
        case (opc)
            OPC_R:      return FMT_R;
            OPC_LOAD:   return FMT_I;
            OPC_STORE:  return FMT_S;
            OPC_BRANCH: return FMT_B;
            default:    return FMT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request and output handshake bundle of the encoder.
//   req_*  : decoded fields in, valid/ready handshake (master drives valid)
//   out_*  : encoded word and its byte address, valid/ready handshake
// Modports: master = program source / loader side, slave = encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [6:0]        req_opcode;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [2:0]        req_funct3;
    logic [6:0]        req_funct7;
    logic [63:0]       req_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output req_valid, req_opcode, req_rd, req_rs1, req_rs2,
               req_funct3, req_funct7, req_imm, out_ready,
        input  req_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  req_valid, req_opcode, req_rd, req_rs1, req_rs2,
               req_funct3, req_funct7, req_imm, out_ready,
        output req_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/instr_pack.sv
// instr_pack: combinational packer from decoded fields to a 32-bit RV64
// instruction word (R, load, store, branch), plus legality flag.
//   f     : decoded fields (branch imm is in halfword units)
//   instr : packed word (0 when bad)
//   bad   : unknown opcode, or out-of-range immediate when
//           IMM_RANGE_CHECK_EN is defined
// Macro: IMM_RANGE_CHECK_EN -- require signed 12-bit immediates for
// load/store/branch; otherwise upper immediate bits are ignored.
module instr_pack
    import rv_pkg::*;
(
    input  instr_fields_t f,
    output logic [31:0]   instr,
    output logic          bad
);

    logic imm_wide;

`ifdef IMM_RANGE_CHECK_EN
    // Signed 12-bit means bits 63..11 are a pure sign extension.
    assign imm_wide = !((&f.imm[63:11]) || !(|f.imm[63:11]));
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^f.imm[63:12];
    assign imm_wide      = 1'b0;
`endif

    always_comb begin
        instr = '0;
        bad   = 1'b0;
        case (opc_fmt(f.opcode))
            FMT_R: instr = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            FMT_I: begin
                instr = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
                bad   = imm_wide;
            end
            FMT_S: begin
                instr = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
                bad   = imm_wide;
            end
            FMT_B: begin
                instr = {f.imm[11], f.imm[9:4], f.rs2, f.rs1, f.funct3,
                         f.imm[3:0], f.imm[10], f.opcode};
                bad   = imm_wide;
            end
            default: bad = 1'b1;
        endcase
        if (bad) instr = '0;
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes decoded instruction requests into 32-bit words,
// tags each with a sequential byte address and buffers them in a FIFO for
// the instruction-memory loader.
//   clk, rst_n        : clock, async active-low reset
//   flush             : clear FIFO (address counter and err_cnt kept)
//   load_base/base_addr: reload address counter (bits [1:0] forced to 0)
//   bus (slave)       : request and output handshakes
//   err_pulse/err_cnt : dropped-request flag and saturating count
// Macro: IMM_RANGE_CHECK_EN (see instr_pack).
module instr_encoder
    import rv_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load_base,
    input  logic [ADDR_W-1:0] base_addr,
    instr_encoder_if.slave    bus,
    output logic              err_pulse,
    output logic [7:0]        err_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    instr_fields_t     fields;
    logic [31:0]       packed_instr;
    logic              bad;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count;
    logic [ADDR_W-1:0] addr_cnt, base_aligned, push_addr;
    logic [31:0]       mem_instr [DEPTH];
    logic [ADDR_W-1:0] mem_addr  [DEPTH];
    logic              accept, push, pop, drop;
    logic              unused_base;

    assign fields = '{opcode: bus.req_opcode, rd: bus.req_rd, rs1: bus.req_rs1,
                      rs2: bus.req_rs2, funct3: bus.req_funct3,
                      funct7: bus.req_funct7, imm: bus.req_imm};

    instr_pack u_pack (
        .f     (fields),
        .instr (packed_instr),
        .bad   (bad)
    );

    assign unused_base  = ^base_addr[1:0];
    assign base_aligned = {base_addr[ADDR_W-1:2], 2'b00};
    // A push in the same cycle as load_base takes the new base.
    assign push_addr    = load_base ? base_aligned : addr_cnt;

    assign bus.req_ready = (count != (PTR_W+1)'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = bus.out_valid ? mem_instr[rd_ptr] : '0;
    assign bus.out_addr  = bus.out_valid ? mem_addr[rd_ptr]  : '0;

    assign accept = bus.req_valid && bus.req_ready && !flush;
    assign push   = accept && !bad;
    assign drop   = accept && bad;
    assign pop    = bus.out_valid && bus.out_ready && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= packed_instr;
            mem_addr[wr_ptr]  <= push_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            addr_cnt  <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= drop;
            if (drop && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                addr_cnt <= push_addr + ADDR_W'(4);
            end else if (load_base) begin
                addr_cnt <= base_aligned;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
